// File: rtl/exp_arbiter.sv
// exp_arbiter
//
// Round-robin arbiter and sequencer sharing one Maclaurin exponential engine (expTop)
// among N_REQ requesters. One argument is accepted at a time. It is forwarded to the
// engine with a one-cycle start pulse. The result is captured on the rising edge of
// done and returned to the originating requester over a valid/ready handshake.
//
// Optional feature: define EXP_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles.
// On expiry a response is returned with rspData = 0 and rspErr = 1. Without the macro
// there is no counter, rspErr is tied low and WAIT lasts until the engine completes.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   asynchronous reset, active high
//   reqValid  in   [N_REQ]        per-requester argument valid
//   reqX      in   [N_REQ*X_W]    arguments, requester i at [i*X_W +: X_W]
//   reqReady  out  [N_REQ]        one-hot accept strobe (IDLE only)
//   rspValid  out  [N_REQ]        one-hot result valid
//   rspReady  in   [N_REQ]        per-requester result accept
//   rspData   out  [R_W]          shared result, qualified by rspValid
//   rspErr    out  1              timeout flag, qualified by rspValid
//   busy      out  1              high in every state except IDLE
//   engStart  out  1              to expTop.start
//   engX      out  [X_W]          to expTop.xBus
//   engR      in   [R_W]          from expTop.rBus
//   engDone   in   1              from expTop.done

module exp_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned X_W     = 16,
  parameter int unsigned R_W     = 18,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       reqValid,
  input  logic [N_REQ*X_W-1:0]   reqX,
  output logic [N_REQ-1:0]       reqReady,
  output logic [N_REQ-1:0]       rspValid,
  input  logic [N_REQ-1:0]       rspReady,
  output logic [R_W-1:0]         rspData,
  output logic                   rspErr,
  output logic                   busy,
  output logic                   engStart,
  output logic [X_W-1:0]         engX,
  input  logic [R_W-1:0]         engR,
  input  logic                   engDone
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] gnt_q, gnt_d;
  logic [X_W-1:0]  eng_x_q, eng_x_d;
  logic [R_W-1:0]  rsp_data_q, rsp_data_d;
  logic            eng_done_q;
  logic            done_evt;

  logic            gnt_found;
  logic [PtrW-1:0] gnt_idx;
  logic [PtrW:0]   scan;
  logic [X_W-1:0]  gnt_x;

`ifdef EXP_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic            rsp_err_q, rsp_err_d;
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_hit;

  // Counter holds the number of WAIT cycles already spent; the last allowed cycle is
  // the one where it equals TIMEOUT-1, giving exactly TIMEOUT WAIT cycles.
  assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT - 1));
  assign rspErr  = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign rspErr         = 1'b0;
`endif

  // Only a fresh rise of done counts; a level left high by a previous operation is
  // ignored because eng_done_q is already high when WAIT is entered.
  assign done_evt = engDone & ~eng_done_q;

  // Rotating-priority search: first asserted reqValid at or above ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan = {1'b0, ptr_q} + (PtrW + 1)'(i);
      if (scan >= (PtrW + 1)'(N_REQ)) begin
        scan = scan - (PtrW + 1)'(N_REQ);
      end
      if (!gnt_found && reqValid[scan[PtrW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[PtrW-1:0];
      end
    end
  end

  // Argument of the requester being granted this cycle.
  always_comb begin
    gnt_x = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == PtrW'(i)) begin
        gnt_x = reqX[i*X_W +: X_W];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    eng_x_d    = eng_x_q;
    rsp_data_d = rsp_data_q;
`ifdef EXP_ARB_TIMEOUT_EN
    rsp_err_d  = rsp_err_q;
    tmo_cnt_d  = tmo_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          gnt_d   = gnt_idx;
          eng_x_d = gnt_x;
          state_d = StIssue;
        end
      end

      StIssue: begin
        state_d = StWait;
`ifdef EXP_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end

      StWait: begin
        // A completion in the limit cycle wins over the timeout.
        if (done_evt) begin
          rsp_data_d = engR;
          state_d    = StResp;
`ifdef EXP_ARB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else if (tmo_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + CntW'(1);
`endif
        end
      end

      StResp: begin
        // Only the granted requester's ready completes the handshake.
        if (rspReady[gnt_q]) begin
          ptr_d   = (gnt_q == PtrW'(N_REQ - 1)) ? '0 : gnt_q + PtrW'(1);
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    reqReady = '0;
    if ((state_q == StIdle) && gnt_found) begin
      reqReady[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    rspValid = '0;
    if (state_q == StResp) begin
      rspValid[gnt_q] = 1'b1;
    end
  end

  assign busy     = (state_q != StIdle);
  assign engStart = (state_q == StIssue);
  assign engX     = eng_x_q;
  assign rspData  = rsp_data_q;

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gnt_q      <= '0;
      eng_x_q    <= '0;
      rsp_data_q <= '0;
      eng_done_q <= 1'b0;
`ifdef EXP_ARB_TIMEOUT_EN
      rsp_err_q  <= 1'b0;
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      eng_x_q    <= eng_x_d;
      rsp_data_q <= rsp_data_d;
      eng_done_q <= engDone;
`ifdef EXP_ARB_TIMEOUT_EN
      rsp_err_q  <= rsp_err_d;
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

endmodule
